// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the 1-to-8 registered dispatcher.
//   WIDTH  : data word width per lane
//   SNUM   : lane-select width (8 lanes)
//   LANES  : number of output lanes
//   CNT_W  : width of the accept counter
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int WIDTH = 32;
    localparam int SNUM  = 3;
    localparam int LANES = 8;
    localparam int CNT_W = 16;

    typedef logic [SNUM-1:0] lane_idx_t;

    // Round-robin successor; the natural SNUM-bit wrap gives 7 -> 0.
    function automatic lane_idx_t next_lane(input lane_idx_t cur);
        return cur + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// ---------------------------------------------------------------------------
// demux_lane_reg
// One-entry holding register for a single output lane.
//   clk, rst_n : clock, async active-low reset
//   load       : capture din this cycle (takes priority over a drain)
//   din        : word to capture
//   ready      : lane consumer takes the held word this cycle
//   data       : held word (keeps its value after a drain)
//   valid      : held word present
// ---------------------------------------------------------------------------
module demux_lane_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] din,
    input  logic             ready,
    output logic [width-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            // Reload wins over a simultaneous drain: no bubble on the lane.
            data  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_dispatch_1to8.sv
// ---------------------------------------------------------------------------
// demux_dispatch_1to8
// Registered, flow-controlled 1-to-8 dispatcher. An input word is accepted
// under valid/ready and parked in the selected lane's one-entry register
// until that lane's consumer takes it. Optional internal round-robin select.
//   clk, rst_n : clock, async active-low reset
//   i          : input data word
//   i_valid    : input word present
//   i_ready    : dispatcher accepts this cycle (combinational)
//   sel        : destination lane when rr_en = 0
//   rr_en      : 1 = use internal round-robin pointer, ignore sel
//   o_data     : packed lane data, lane k at [k*width +: width]
//   o_valid    : per-lane valid
//   o_ready    : per-lane consumer ready
//   acc_cnt    : wrapping count of accepted words
// Only snum = 3 (8 lanes) is supported.
// ---------------------------------------------------------------------------
module demux_dispatch_1to8
    import demux_pkg::*;
#(
    parameter int width = 32,
    parameter int snum  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [width-1:0]       i,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [snum-1:0]        sel,
    input  logic                   rr_en,
    output logic [LANES*width-1:0] o_data,
    output logic [LANES-1:0]       o_valid,
    input  logic [LANES-1:0]       o_ready,
    output logic [CNT_W-1:0]       acc_cnt
);

    lane_idx_t          rr_ptr;
    lane_idx_t          dest;
    logic               accept;
    logic [LANES-1:0]   lane_load;
    logic [LANES-1:0]   lane_valid;
    logic [width-1:0]   lane_data [LANES];

    assign dest = rr_en ? rr_ptr : lane_idx_t'(sel);

    // A lane can take a new word if it is empty or is being drained now.
    assign i_ready = ~lane_valid[dest] | o_ready[dest];
    assign accept  = i_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (rr_en) begin
                rr_ptr <= next_lane(rr_ptr);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_load[k] = accept && (dest == lane_idx_t'(k));

        demux_lane_reg #(
            .width (width)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (lane_load[k]),
            .din   (i),
            .ready (o_ready[k]),
            .data  (lane_data[k]),
            .valid (lane_valid[k])
        );

        assign o_data[k*width +: width] = lane_data[k];
    end

    assign o_valid = lane_valid;

endmodule

// File: tb/tb_demux_dispatch_1to8.sv
module tb_demux_dispatch_1to8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i;
    logic         i_valid;
    logic         i_ready;
    logic [2:0]   sel;
    logic         rr_en;
    logic [255:0] o_data;
    logic [7:0]   o_valid;
    logic [7:0]   o_ready;
    logic [15:0]  acc_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model, advanced on the negedge ahead of each posedge.
    logic [31:0] exp_q [8][$];
    logic [7:0]  m_valid = '0;
    logic [2:0]  m_rr    = '0;
    logic [15:0] m_cnt   = '0;

    demux_dispatch_1to8 #(.width(32), .snum(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .sel     (sel),
        .rr_en   (rr_en),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .acc_cnt (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int k);
        return o_data[k*32 +: 32];
    endfunction

    // Scoreboard: words pushed on accept, popped when the lane drains.
    always @(negedge clk) begin
        logic [2:0]  d;
        logic        er;
        logic [7:0]  nv;
        logic [31:0] e;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) exp_q[k].delete();
            m_valid = '0;
            m_rr    = '0;
            m_cnt   = '0;
        end else begin
            check("sb_o_valid", 256'(o_valid), 256'(m_valid));
            check("sb_acc_cnt", 256'(acc_cnt), 256'(m_cnt));
            d  = rr_en ? m_rr : sel;
            er = ~m_valid[d] | o_ready[d];
            check("sb_i_ready", 256'(i_ready), 256'(er));
            nv = m_valid;
            for (int k = 0; k < 8; k++) begin
                if (m_valid[k] && o_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("sb_underflow", 256'(1), 256'(0));
                    end else begin
                        e = exp_q[k].pop_front();
                        check("sb_lane_data", 256'(lane(k)), 256'(e));
                    end
                    nv[k] = 1'b0;
                end
            end
            if (i_valid && er) begin
                exp_q[d].push_back(i);
                nv[d] = 1'b1;
                m_cnt = m_cnt + 16'd1;
                if (rr_en) m_rr = m_rr + 3'd1;
            end
            m_valid = nv;
        end
    end

    initial begin
        rst_n   = 1'b0;
        i       = '0;
        i_valid = 1'b0;
        sel     = '0;
        rr_en   = 1'b0;
        o_ready = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_o_valid", 256'(o_valid), 256'(0));
        check("rst_o_data", o_data, 256'(0));
        check("rst_i_ready", 256'(i_ready), 256'(1));
        check("rst_acc_cnt", 256'(acc_cnt), 256'(0));

        // Explicit select, one word per cycle
        i = 32'hA000_0000; sel = 3'd0; i_valid = 1'b1;
        step();
        check("sel_l0_valid", 256'(o_valid[0]), 256'(1));
        check("sel_l0_data", 256'(lane(0)), 256'(32'hA000_0000));
        i = 32'hB000_0000; sel = 3'd1;
        step();
        i_valid = 1'b0;
        check("sel_l1_valid", 256'(o_valid[1]), 256'(1));
        check("sel_l1_data", 256'(lane(1)), 256'(32'hB000_0000));
        check("sel_acc_cnt", 256'(acc_cnt), 256'(2));
        step();

        // Backpressure on lane 3
        o_ready = 8'hF7;
        i = 32'h1111_1111; sel = 3'd3; i_valid = 1'b1;
        check("bp_first_ready", 256'(i_ready), 256'(1));
        step();
        i = 32'h2222_2222;
        check("bp_second_blocked", 256'(i_ready), 256'(0));
        step();
        check("bp_l3_hold", 256'(lane(3)), 256'(32'h1111_1111));
        check("bp_cnt_hold", 256'(acc_cnt), 256'(3));
        o_ready = 8'hFF;
        #1 check("bp_release_ready", 256'(i_ready), 256'(1));
        step();
        i_valid = 1'b0;
        check("bp_l3_valid", 256'(o_valid[3]), 256'(1));
        check("bp_l3_data", 256'(lane(3)), 256'(32'h2222_2222));
        check("bp_acc_cnt", 256'(acc_cnt), 256'(4));
        step();

        // Round-robin wrap
        rr_en = 1'b1; i_valid = 1'b1;
        for (int v = 0; v < 10; v++) begin
            i = 32'(v);
            step();
            check("rr_lane_data", 256'(lane(v % 8)), 256'(v));
        end
        i = 32'hCAFE_0002;
        step();
        check("rr_ptr_at_2", 256'(lane(2)), 256'(32'hCAFE_0002));
        i_valid = 1'b0; rr_en = 1'b0;
        step();

        // Independence: lane 5 full and stalled, lane 6 keeps streaming
        o_ready = 8'hDF;
        i = 32'h0000_0055; sel = 3'd5; i_valid = 1'b1;
        step();
        for (int j = 0; j < 4; j++) begin
            i = 32'h0000_0500 + 32'(j); sel = 3'd5;
            #1 check("ind_l5_blocked", 256'(i_ready), 256'(0));
            step();
            i = 32'h0000_0600 + 32'(j); sel = 3'd6;
            #1 check("ind_l6_ready", 256'(i_ready), 256'(1));
            step();
            check("ind_l6_data", 256'(lane(6)), 256'(32'h0000_0600 + 32'(j)));
        end
        i_valid = 1'b0;
        check("ind_l5_kept", 256'(lane(5)), 256'(32'h0000_0055));
        o_ready = 8'hFF;
        step();

        // Counter wrap
        sel = 3'd7; i_valid = 1'b1;
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) begin
            i = 32'(n);
            step();
        end
        check("cnt_at_max", 256'(acc_cnt), 256'(16'hFFFF));
        i = 32'h0BAD_F00D;
        step();
        i_valid = 1'b0;
        check("cnt_wrap", 256'(acc_cnt), 256'(0));
        step();

        // Async reset mid-stream
        o_ready = 8'h00; i_valid = 1'b1;
        i = 32'h0000_00A0; sel = 3'd0;
        step();
        i = 32'h0000_00A4; sel = 3'd4;
        step();
        i_valid = 1'b0;
        check("ar_lanes_full", 256'(o_valid), 256'(8'h11));
        #2 rst_n = 1'b0;
        #1;
        check("ar_o_valid", 256'(o_valid), 256'(0));
        check("ar_o_data", o_data, 256'(0));
        check("ar_acc_cnt", 256'(acc_cnt), 256'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        o_ready = 8'hFF; rr_en = 1'b1; i_valid = 1'b1; i = 32'h00C0_FFEE;
        step();
        i_valid = 1'b0; rr_en = 1'b0;
        check("ar_rr_lane0_valid", 256'(o_valid), 256'(8'h01));
        check("ar_rr_lane0_data", 256'(lane(0)), 256'(32'h00C0_FFEE));
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
